// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
//  - Default memory window (base address and size in bytes).
//  - Owner encoding carried in the response tag.
//  - Word-alignment mask used by the address checker.
package imem_port_arbiter_pkg;

  localparam logic [31:0] ADDR_BASE_DEFAULT  = 32'h0100_0000;
  localparam logic [31:0] MEM_BYTES_DEFAULT  = 32'h0010_0000;
  localparam int          STARVE_LIMIT_DEFAULT = 4;

  // Low address bits that must be zero for a word access.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

  // Requester that owns the access issued in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

endpackage : imem_port_arbiter_pkg

// File: rtl/imem_addr_check.sv
// Combinational address checker for one requester.
// Flags an access that is not word aligned or falls outside the
// window [ADDR_BASE, ADDR_BASE + MEM_BYTES).
// Ports:
//  addr  in   32  byte address of the request
//  err   out  1   1 = misaligned or out of range
module imem_addr_check
  import imem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter logic [31:0] MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic [31:0] addr,
  output logic        err
);

  // 33-bit arithmetic so a window ending at 4 GiB does not wrap to zero.
  logic [32:0] addr_ext;
  logic [32:0] lo_bound;
  logic [32:0] hi_bound;
  logic        misaligned;
  logic        out_of_range;

  assign addr_ext     = {1'b0, addr};
  assign lo_bound     = {1'b0, ADDR_BASE};
  assign hi_bound     = {1'b0, ADDR_BASE} + {1'b0, MEM_BYTES};
  assign misaligned   = (addr & WORD_ALIGN_MASK) != 32'd0;
  assign out_of_range = (addr_ext < lo_bound) || (addr_ext >= hi_bound);
  assign err          = misaligned || out_of_range;

endmodule : imem_addr_check

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between instruction fetch
// (IF, read-only) and load/store (LS, read/write). One request is issued
// per cycle; the owner gets its response in the following cycle, built
// from a registered tag and the memory's registered read data.
// LS has priority, but after STARVE_LIMIT consecutive LS grants with IF
// waiting, IF is forced through.
// Ports:
//  clock, reset                   clock / synchronous active-high reset
//  if_req_*  / if_flush           fetch request channel and redirect
//  if_rsp_*                       fetch response (valid, data, err)
//  ls_req_*                       load/store request channel
//  ls_rsp_*                       load/store response (valid, data, err)
//  mem_address/read_write/data_in to the memory instance
//  mem_data_out                   from the memory, valid cycle after address
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = ADDR_BASE_DEFAULT,
  parameter logic [31:0] MEM_BYTES    = MEM_BYTES_DEFAULT,
  parameter int          STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  // fetch port
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  // load/store port
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_req_addr,
  input  logic        ls_req_we,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        ls_rsp_err,
  // memory side
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  logic if_err;
  logic ls_err;

  imem_addr_check #(.ADDR_BASE(ADDR_BASE), .MEM_BYTES(MEM_BYTES)) u_if_check (
    .addr (if_req_addr),
    .err  (if_err)
  );

  imem_addr_check #(.ADDR_BASE(ADDR_BASE), .MEM_BYTES(MEM_BYTES)) u_ls_check (
    .addr (ls_req_addr),
    .err  (ls_err)
  );

  logic [CW-1:0] starve_cnt_reg;
  owner_e        tag_owner_reg;
  logic          tag_err_reg;
  logic          tag_store_reg;

  // ---------------- arbitration ----------------
  logic if_eligible;
  logic ls_grant;
  logic if_grant;

  assign if_eligible = if_req_valid && !if_flush;
  // LS also wins past the starvation limit when IF cannot take the slot
  // (not valid or blocked by flush), so the port is never left idle.
  assign ls_grant = !reset && ls_req_valid &&
                    ((starve_cnt_reg < STARVE_MAX) || !if_eligible);
  assign if_grant = !reset && if_eligible && !ls_grant;

  assign ls_req_ready = ls_grant;
  assign if_req_ready = if_grant;

  // ---------------- memory drive (issue cycle) ----------------
  always_comb begin
    mem_address    = ADDR_BASE;
    mem_read_write = 1'b0;
    mem_data_in    = 32'd0;
    if (ls_grant) begin
      mem_address    = ls_req_addr;
      mem_read_write = ls_req_we && !ls_err;
      mem_data_in    = ls_req_wdata;
    end else if (if_grant) begin
      mem_address    = if_req_addr;
    end
  end

  // ---------------- starve counter and response tag ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_reg <= '0;
      tag_owner_reg  <= OWN_NONE;
      tag_err_reg    <= 1'b0;
      tag_store_reg  <= 1'b0;
    end else begin
      if (if_grant || !if_req_valid) begin
        starve_cnt_reg <= '0;
      end else if (ls_grant && (starve_cnt_reg != STARVE_MAX)) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end

      if (ls_grant) begin
        tag_owner_reg <= OWN_LS;
        tag_err_reg   <= ls_err;
        tag_store_reg <= ls_req_we;
      end else if (if_grant) begin
        tag_owner_reg <= OWN_IF;
        tag_err_reg   <= if_err;
        tag_store_reg <= 1'b0;
      end else begin
        tag_owner_reg <= OWN_NONE;
        tag_err_reg   <= 1'b0;
        tag_store_reg <= 1'b0;
      end
    end
  end

  // ---------------- response (cycle after issue) ----------------
  // Reset masks the response in the reset cycle itself; the tag is
  // cleared by then, so nothing appears in the cycle after reset either.
  // A flush drops a fetch response presented in the same cycle.
  logic        if_pending;
  logic        ls_pending;
  logic [31:0] rsp_data;

  assign if_pending = !reset && !if_flush && (tag_owner_reg == OWN_IF);
  assign ls_pending = !reset && (tag_owner_reg == OWN_LS);
  assign rsp_data   = (tag_err_reg || tag_store_reg) ? 32'd0 : mem_data_out;

  assign if_rsp_valid = if_pending;
  assign if_rsp_err   = if_pending && tag_err_reg;
  assign if_rsp_data  = if_pending ? rsp_data : 32'd0;

  assign ls_rsp_valid = ls_pending;
  assign ls_rsp_err   = ls_pending && tag_err_reg;
  assign ls_rsp_data  = ls_pending ? rsp_data : 32'd0;

endmodule : imem_port_arbiter

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter with a small behavioural
// memory (registered read, write on clock edge, read-before-write).
module tb_imem_port_arbiter;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_flush;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we;
  logic [31:0] ls_req_addr, ls_req_wdata;
  logic        ls_rsp_valid, ls_rsp_err;
  logic [31:0] ls_rsp_data;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];

  always #5 clock = ~clock;

  imem_port_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_flush       (if_flush),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .if_rsp_err     (if_rsp_err),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_req_addr    (ls_req_addr),
    .ls_req_we      (ls_req_we),
    .ls_req_wdata   (ls_req_wdata),
    .ls_rsp_valid   (ls_rsp_valid),
    .ls_rsp_data    (ls_rsp_data),
    .ls_rsp_err     (ls_rsp_err),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out)
  );

  // Memory model: word index from address bits [9:2].
  always @(posedge clock) begin
    mem_data_out <= mem[mem_address[9:2]];
    if (mem_read_write) mem[mem_address[9:2]] = mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_req_valid = 1'b0; if_req_addr = BASE; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_req_addr = BASE; ls_req_we = 1'b0; ls_req_wdata = 32'd0;
  endtask

  // Commit the current cycle and move to just after the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0]   = 32'h0000_0013;
    mem[1]   = 32'h1111_0004;
    mem[4]   = 32'hCAFE_0010;
    mem[255] = 32'hA5A5_0FFC;

    idle();
    reset = 1'b1;
    ls_req_valid = 1'b1;               // must not be granted during reset
    tick(); mid();
    check("rst_ls_ready", {31'd0, ls_req_ready}, 32'd0);
    check("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    check("rst_mem_addr", mem_address, BASE);
    check("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);
    tick();
    reset = 1'b0; idle();
    $display("txn reset done");

    // IF read @BASE
    if_req_valid = 1'b1; if_req_addr = BASE;
    mid();
    check("if0_ready", {31'd0, if_req_ready}, 32'd1);
    check("if0_mem_addr", mem_address, BASE);
    tick(); idle(); mid();
    check("if0_rsp_valid", {31'd0, if_rsp_valid}, 32'd1);
    check("if0_rsp_data", if_rsp_data, 32'h0000_0013);
    check("if0_rsp_err", {31'd0, if_rsp_err}, 32'd0);
    $display("txn IF read 0x%08h", BASE);

    // IF and LS together: LS first, IF next cycle
    tick();
    if_req_valid = 1'b1; if_req_addr = BASE + 32'h4;
    ls_req_valid = 1'b1; ls_req_addr = BASE + 32'h10;
    mid();
    check("both_ls_ready", {31'd0, ls_req_ready}, 32'd1);
    check("both_if_ready", {31'd0, if_req_ready}, 32'd0);
    tick();
    ls_req_valid = 1'b0;
    mid();
    check("both_ls_rsp_valid", {31'd0, ls_rsp_valid}, 32'd1);
    check("both_ls_rsp_data", ls_rsp_data, 32'hCAFE_0010);
    check("both_if_ready2", {31'd0, if_req_ready}, 32'd1);
    tick(); idle(); mid();
    check("both_if_rsp_data", if_rsp_data, 32'h1111_0004);
    check("both_ls_rsp_idle", {31'd0, ls_rsp_valid}, 32'd0);
    $display("txn LS load then IF fetch");

    // Store then back-to-back load
    tick();
    ls_req_valid = 1'b1; ls_req_addr = BASE + 32'h20; ls_req_we = 1'b1; ls_req_wdata = 32'hDEAD_BEEF;
    mid();
    check("st_mem_rw", {31'd0, mem_read_write}, 32'd1);
    check("st_mem_din", mem_data_in, 32'hDEAD_BEEF);
    tick();
    ls_req_we = 1'b0; ls_req_wdata = 32'd0;
    mid();
    check("st_rsp_valid", {31'd0, ls_rsp_valid}, 32'd1);
    check("st_rsp_data", ls_rsp_data, 32'd0);
    check("ld_ready_b2b", {31'd0, ls_req_ready}, 32'd1);
    tick(); idle(); mid();
    check("ld_after_st", ls_rsp_data, 32'hDEAD_BEEF);
    $display("txn store/load 0xDEADBEEF");

    // Starvation: 4 LS, 1 IF, repeating
    tick();
    for (int i = 0; i < 10; i++) begin
      if_req_valid = 1'b1; if_req_addr = BASE;
      ls_req_valid = 1'b1; ls_req_addr = BASE + 32'h10;
      mid();
      check($sformatf("starve_ls_%0d", i), {31'd0, ls_req_ready}, {31'd0, (i % 5) != 4});
      check($sformatf("starve_if_%0d", i), {31'd0, if_req_ready}, {31'd0, (i % 5) == 4});
      tick();
    end
    idle(); tick();
    $display("txn starvation pattern");

    // Misaligned store: slot used, no write
    ls_req_valid = 1'b1; ls_req_addr = BASE + 32'h2; ls_req_we = 1'b1; ls_req_wdata = 32'h1234_5678;
    mid();
    check("mis_ready", {31'd0, ls_req_ready}, 32'd1);
    check("mis_mem_rw", {31'd0, mem_read_write}, 32'd0);
    tick();
    ls_req_addr = BASE; ls_req_we = 1'b0; ls_req_wdata = 32'd0;
    mid();
    check("mis_rsp_err", {31'd0, ls_rsp_err}, 32'd1);
    check("mis_rsp_data", ls_rsp_data, 32'd0);
    tick(); idle(); mid();
    check("mis_mem_unchanged", ls_rsp_data, 32'h0000_0013);
    check("mis_ld_err", {31'd0, ls_rsp_err}, 32'd0);
    $display("txn misaligned store");

    // Fetch range boundaries
    tick();
    if_req_valid = 1'b1; if_req_addr = 32'h0110_0000;
    tick(); if_req_addr = 32'h010F_FFFC;
    mid();
    check("oor_hi_valid", {31'd0, if_rsp_valid}, 32'd1);
    check("oor_hi_err", {31'd0, if_rsp_err}, 32'd1);
    check("oor_hi_data", if_rsp_data, 32'd0);
    tick(); if_req_addr = 32'h00FF_FFFC;
    mid();
    check("last_word_err", {31'd0, if_rsp_err}, 32'd0);
    check("last_word_data", if_rsp_data, 32'hA5A5_0FFC);
    tick(); idle(); mid();
    check("oor_lo_err", {31'd0, if_rsp_err}, 32'd1);
    $display("txn fetch range checks");

    // Flush: IF granted in N, flush in N+1
    tick();
    if_req_valid = 1'b1; if_req_addr = BASE;
    mid();
    check("fl_if_ready_n", {31'd0, if_req_ready}, 32'd1);
    tick();
    if_flush = 1'b1;
    ls_req_valid = 1'b1; ls_req_addr = BASE + 32'h10;
    mid();
    check("fl_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    check("fl_if_ready", {31'd0, if_req_ready}, 32'd0);
    check("fl_ls_ready", {31'd0, ls_req_ready}, 32'd1);
    tick(); idle(); mid();
    check("fl_rsp_after", {31'd0, if_rsp_valid}, 32'd0);
    check("fl_ls_rsp", ls_rsp_data, 32'hCAFE_0010);
    $display("txn flush");

    // Reset in the cycle after a store grant
    tick();
    ls_req_valid = 1'b1; ls_req_addr = BASE + 32'h30; ls_req_we = 1'b1; ls_req_wdata = 32'h0000_0077;
    tick();
    reset = 1'b1;
    ls_req_addr = BASE + 32'h34; ls_req_wdata = 32'h0000_0088;
    mid();
    check("rm_ls_ready", {31'd0, ls_req_ready}, 32'd0);
    check("rm_rsp_valid", {31'd0, ls_rsp_valid}, 32'd0);
    check("rm_mem_rw", {31'd0, mem_read_write}, 32'd0);
    check("rm_mem_addr", mem_address, BASE);
    tick();
    reset = 1'b0; idle();
    mid();
    check("rm_no_rsp_after", {31'd0, ls_rsp_valid}, 32'd0);
    ls_req_valid = 1'b1; ls_req_addr = BASE + 32'h34;
    tick();
    ls_req_addr = BASE + 32'h30;
    mid();
    check("rm_store_dropped", ls_rsp_data, 32'd0);
    tick(); idle(); mid();
    check("rm_store_before", ls_rsp_data, 32'h0000_0077);
    $display("txn reset mid-operation");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_port_arbiter
